// File: rtl/gpio_handshake_xactor.sv
// GPIO code/response handshake transactor: waits for each expected code, drives a delayed response, then checks its echo.
// Optional build macro GPIO_HS_DEBOUNCE_EN: a code must be seen on two consecutive edges before it is accepted.
module gpio_handshake_xactor #(
   parameter int                          HALF_W     = 8,
   parameter int                          NUM_STEPS  = 4,
   parameter int                          CNT_W      = 16,
   parameter logic [NUM_STEPS*HALF_W-1:0] EXPECT_SEQ = '0,
   parameter logic [NUM_STEPS*HALF_W-1:0] RESP_SEQ   = '0,
   parameter logic [NUM_STEPS*CNT_W-1:0]  DELAY_SEQ  = '0,
   parameter int                          TIMEOUT    = 25000,
   localparam int                         SW         = $clog2(NUM_STEPS) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [HALF_W-1:0] mon_in,
   input  logic [HALF_W-1:0] echo_in,
   output logic [HALF_W-1:0] resp_out,
   output logic              resp_oe,
   output logic [SW-1:0]     step_idx,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic [SW-1:0]     fail_step
);

   typedef enum logic [2:0] {IDLE, WAIT_CODE, DELAY, ECHO, PASS, FAIL} state_t;

   localparam int NE = 1 << SW;

   state_t             state, state_n;
   logic [CNT_W-1:0]   wdog, wdog_n, wdog_inc;
   logic [CNT_W-1:0]   dcnt, dcnt_n;
   logic [HALF_W-1:0]  resp_n;
   logic               oe_n, busy_n, pass_n, fail_n;
   logic [SW-1:0]      step_n, fstep_n;

   // Tables padded to a power of two so step_idx indexes them at full width
   logic [HALF_W-1:0]  exp_tab   [NE];
   logic [HALF_W-1:0]  resp_tab  [NE];
   logic [CNT_W-1:0]   delay_tab [NE];

   for (genvar i = 0; i < NE; i++) begin : g_tab
      if (i < NUM_STEPS) begin : g_v
         assign exp_tab[i]   = EXPECT_SEQ[i*HALF_W +: HALF_W];
         assign resp_tab[i]  = RESP_SEQ[i*HALF_W +: HALF_W];
         assign delay_tab[i] = DELAY_SEQ[i*CNT_W +: CNT_W];
      end else begin : g_z
         assign exp_tab[i]   = '0;
         assign resp_tab[i]  = '0;
         assign delay_tab[i] = '0;
      end
   end

   logic [HALF_W-1:0] cur_resp;
   logic [CNT_W-1:0]  cur_delay;
   logic              cur_match, code_hit, echo_hit, timed_out, last_step;

   assign cur_resp  = resp_tab[step_idx];
   assign cur_delay = delay_tab[step_idx];
   assign cur_match = (mon_in == exp_tab[step_idx]);
   assign echo_hit  = (echo_in == cur_resp);
   assign last_step = (step_idx == SW'(NUM_STEPS - 1));
   // The edge on which the counter would reach TIMEOUT
   assign timed_out = (32'(wdog) >= TIMEOUT - 1);
   assign wdog_inc  = (wdog == '1) ? wdog : wdog + 1'b1;

`ifdef GPIO_HS_DEBOUNCE_EN
   logic prev_match;
   assign code_hit = cur_match & prev_match;

   always_ff @(posedge clock) begin
      if (reset)
         prev_match <= 1'b0;
      else
         prev_match <= (state == WAIT_CODE) && !code_hit && cur_match;
   end
`else
   assign code_hit = cur_match;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         wdog      <= '0;
         dcnt      <= '0;
         resp_out  <= '0;
         resp_oe   <= 1'b0;
         step_idx  <= '0;
         busy      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_step <= '0;
      end else begin
         state     <= state_n;
         wdog      <= wdog_n;
         dcnt      <= dcnt_n;
         resp_out  <= resp_n;
         resp_oe   <= oe_n;
         step_idx  <= step_n;
         busy      <= busy_n;
         pass      <= pass_n;
         fail      <= fail_n;
         fail_step <= fstep_n;
      end
   end

   always_comb begin
      state_n = state;
      wdog_n  = wdog;
      dcnt_n  = dcnt;
      resp_n  = resp_out;
      oe_n    = resp_oe;
      step_n  = step_idx;
      busy_n  = busy;
      pass_n  = pass;
      fail_n  = fail;
      fstep_n = fail_step;
      case (state)
         IDLE, PASS, FAIL: begin
            if (start) begin
               state_n = WAIT_CODE;
               step_n  = '0;
               wdog_n  = '0;
               busy_n  = 1'b1;
               pass_n  = 1'b0;
               fail_n  = 1'b0;
               oe_n    = 1'b0;
            end
         end
         WAIT_CODE: begin
            wdog_n = wdog_inc;
            if (code_hit) begin
               if (cur_delay == '0) begin
                  resp_n  = cur_resp;
                  oe_n    = 1'b1;
                  state_n = ECHO;
               end else begin
                  dcnt_n  = '0;
                  state_n = DELAY;
               end
            end else if (timed_out) begin
               state_n = FAIL;
               fail_n  = 1'b1;
               busy_n  = 1'b0;
               fstep_n = step_idx;
            end
         end
         DELAY: begin
            // dcnt holds edges already spent in DELAY minus one
            if (dcnt == cur_delay - 1'b1) begin
               resp_n  = cur_resp;
               oe_n    = 1'b1;
               state_n = ECHO;
            end else begin
               dcnt_n = (dcnt == '1) ? dcnt : dcnt + 1'b1;
            end
         end
         ECHO: begin
            if (echo_hit) begin
               if (last_step) begin
                  state_n = PASS;
                  pass_n  = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  step_n  = step_idx + 1'b1;
                  wdog_n  = '0;
                  state_n = WAIT_CODE;
               end
            end else if (timed_out) begin
               state_n = FAIL;
               fail_n  = 1'b1;
               busy_n  = 1'b0;
               fstep_n = step_idx;
            end else begin
               wdog_n = wdog_inc;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
